// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared types and constants for the memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUS_IF  = 2'd1,
        ARB_BUS_MEM = 2'd2,
        ARB_DROP_IF = 2'd3
    } arb_state_t;

    // Instruction fetches always read a full word.
    localparam logic [3:0] c_sel_word = 4'b1111;

    // Upper bound of the watchdog limit; sizes the watchdog counter.
    localparam int c_timeout_max = 1023;

    // A bus cycle is outstanding in every state except IDLE.
    function automatic logic is_busy(input arb_state_t state);
        return state != ARB_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_watchdog
// Description : Counts bus cycles without a slave ack and flags the cycle in
//               which the TIMEOUT-th unacknowledged cycle is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int         c_cnt_w = $clog2(c_timeout_max + 2);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_count;
    logic               r_expired;

    // Count unacknowledged cycles; expired is raised one cycle early so the
    // FSM aborts on the edge that would make the count reach TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else if (i_clear) begin
            r_count   <= '0;
            r_expired <= (TIMEOUT == 1);
        end else if (i_enable) begin
            r_count   <= r_count + 1'b1;
            r_expired <= ((r_count + c_cnt_w'(2)) == c_limit);
        end
    end

    assign o_expired = r_expired;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one external memory bus between the fetch port and
//               the load/store port (load/store has priority), sequences the
//               req/ack handshake, raises pipeline stalls and aborts bus
//               cycles that never get acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    input  logic              flush_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o,
    output logic              stallreq_o
);

    arb_state_t        r_state;
    logic [DATA_W-1:0] r_if_data;
    logic              r_if_ack;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_mem_ack;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [3:0]        r_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_bus_err;

    logic w_mem_go;
    logic w_if_go;
    logic w_grant;
    logic w_count_en;
    logic w_expired;

    // A port whose ack is on the outputs this cycle still shows its old
    // request; it must not be granted a second time.
    assign w_mem_go   = mem_req_i & ~r_mem_ack;
    assign w_if_go    = if_req_i & ~flush_i & ~r_if_ack;
    assign w_grant    = (r_state == ARB_IDLE) & (w_mem_go | w_if_go);
    assign w_count_en = is_busy(r_state) & ~bus_ack_i;

    mem_bus_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_grant),
        .i_enable  (w_count_en),
        .o_expired (w_expired)
    );

    // Arbitration FSM with registered bus, ack, error and data outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ARB_IDLE;
            r_if_data   <= '0;
            r_if_ack    <= 1'b0;
            r_mem_rdata <= '0;
            r_mem_ack   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_mem_go) begin
                        r_state     <= ARB_BUS_MEM;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_we_i;
                        r_bus_sel   <= mem_sel_i;
                        r_bus_addr  <= mem_addr_i;
                        r_bus_wdata <= mem_wdata_i;
                    end else if (w_if_go) begin
                        r_state     <= ARB_BUS_IF;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_sel   <= c_sel_word;
                        r_bus_addr  <= if_addr_i;
                        r_bus_wdata <= '0;
                    end
                end
                ARB_BUS_IF: begin
                    if (flush_i) begin
                        // The bus cycle cannot be withdrawn; discard its result.
                        if (bus_ack_i) begin
                            r_state   <= ARB_IDLE;
                            r_bus_req <= 1'b0;
                        end else if (w_expired) begin
                            r_state   <= ARB_IDLE;
                            r_bus_req <= 1'b0;
                            r_bus_err <= 1'b1;
                        end else begin
                            r_state   <= ARB_DROP_IF;
                        end
                    end else if (bus_ack_i) begin
                        r_state   <= ARB_IDLE;
                        r_bus_req <= 1'b0;
                        r_if_data <= bus_rdata_i;
                        r_if_ack  <= 1'b1;
                    end else if (w_expired) begin
                        r_state   <= ARB_IDLE;
                        r_bus_req <= 1'b0;
                        r_if_data <= '0;
                        r_if_ack  <= 1'b1;
                        r_bus_err <= 1'b1;
                    end
                end
                ARB_BUS_MEM: begin
                    if (bus_ack_i) begin
                        r_state     <= ARB_IDLE;
                        r_bus_req   <= 1'b0;
                        r_mem_rdata <= bus_rdata_i;
                        r_mem_ack   <= 1'b1;
                    end else if (w_expired) begin
                        r_state     <= ARB_IDLE;
                        r_bus_req   <= 1'b0;
                        r_mem_rdata <= '0;
                        r_mem_ack   <= 1'b1;
                        r_bus_err   <= 1'b1;
                    end
                end
                ARB_DROP_IF: begin
                    if (bus_ack_i) begin
                        r_state   <= ARB_IDLE;
                        r_bus_req <= 1'b0;
                    end else if (w_expired) begin
                        r_state   <= ARB_IDLE;
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign if_data_o   = r_if_data;
    assign if_ack_o    = r_if_ack;
    assign mem_rdata_o = r_mem_rdata;
    assign mem_ack_o   = r_mem_ack;
    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_sel_o   = r_bus_sel;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;
    assign bus_err_o   = r_bus_err;

    // Stall while any requester is still waiting; forced low in reset.
    assign stallreq_o = rst & ((if_req_i & ~r_if_ack & ~flush_i) |
                               (mem_req_i & ~r_mem_ack));

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter: directed scenarios
//               followed by randomized traffic against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, flush, bus_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic [31:0] if_data, mem_rdata, bus_addr, bus_wdata;
    logic        if_ack, mem_ack, bus_req, bus_we, bus_err, stallreq;
    logic [3:0]  bus_sel;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ack_o(if_ack),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack), .flush_i(flush),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
        .bus_ack_i(bus_ack), .bus_err_o(bus_err), .stallreq_o(stallreq)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model: one outstanding bus transaction record.
    bit          m_busy, m_own_mem, m_drop;
    int          m_waited;
    logic [31:0] m_addr, m_wdata, m_if_data, m_mem_data;
    logic [3:0]  m_sel;
    logic        m_we, m_if_ack, m_mem_ack, m_err;

    // Slave behaviour: 0 = scripted delay, 1 = random.
    int          sl_mode, sl_delay, sl_age;
    logic [31:0] sl_data;

    // Observations of the DUT used by the literal scenario checks.
    int          cyc, n_if_ack, n_mem_ack, n_err, n_both, n_req_cycles;
    logic [31:0] addr_log[$];
    int          rise_cyc[$];
    logic        prev_bus_req, last_we;
    logic [3:0]  last_sel;
    logic [31:0] last_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_own_mem = 0; m_drop = 0; m_waited = 0;
        m_addr = '0; m_wdata = '0; m_sel = '0; m_we = 1'b0;
        m_if_data = '0; m_mem_data = '0;
        m_if_ack = 1'b0; m_mem_ack = 1'b0; m_err = 1'b0;
    endtask

    task automatic start_txn(input bit own_mem, input logic [31:0] a, input logic we,
                             input logic [3:0] sel, input logic [31:0] wd);
        m_busy = 1; m_own_mem = own_mem; m_drop = 0; m_waited = 0;
        m_addr = a; m_we = we; m_sel = sel; m_wdata = wd;
    endtask

    task automatic deliver(input logic [31:0] d);
        if (m_own_mem) begin m_mem_ack = 1'b1; m_mem_data = d; end
        else           begin m_if_ack  = 1'b1; m_if_data  = d; end
    endtask

    // Advance the model by one clock using the inputs seen at this edge.
    task automatic model_step();
        logic pia, pma;
        bit   discard;
        pia = m_if_ack;
        pma = m_mem_ack;
        m_if_ack = 1'b0; m_mem_ack = 1'b0; m_err = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (mem_req && !pma)
                start_txn(1, mem_addr, mem_we, mem_sel, mem_wdata);
            else if (if_req && !flush && !pia)
                start_txn(0, if_addr, 1'b0, 4'hF, 32'h0);
        end else begin
            discard = !m_own_mem && (m_drop || flush);
            if (bus_ack) begin
                m_busy = 0;
                if (!discard) deliver(bus_rdata);
            end else if (m_waited + 1 == TO) begin
                m_busy = 0;
                m_err  = 1'b1;
                if (!discard) deliver(32'h0);
            end else begin
                m_waited++;
                if (!m_own_mem && flush) m_drop = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_stall;
        exp_stall = rst && ((if_req && !m_if_ack && !flush) || (mem_req && !m_mem_ack));
        check("bus_req",   64'(bus_req),   64'(m_busy));
        check("if_ack",    64'(if_ack),    64'(m_if_ack));
        check("mem_ack",   64'(mem_ack),   64'(m_mem_ack));
        check("bus_err",   64'(bus_err),   64'(m_err));
        check("if_data",   64'(if_data),   64'(m_if_data));
        check("mem_rdata", 64'(mem_rdata), 64'(m_mem_data));
        check("stallreq",  64'(stallreq),  64'(exp_stall));
        if (m_busy) begin
            check("bus_addr",  64'(bus_addr),  64'(m_addr));
            check("bus_we",    64'(bus_we),    64'(m_we));
            check("bus_sel",   64'(bus_sel),   64'(m_sel));
            check("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
        end
    endtask

    task automatic observe();
        if (bus_req && !prev_bus_req) begin
            addr_log.push_back(bus_addr);
            rise_cyc.push_back(cyc);
            last_we = bus_we; last_sel = bus_sel; last_wdata = bus_wdata;
        end
        n_if_ack     += int'(if_ack);
        n_mem_ack    += int'(mem_ack);
        n_err        += int'(bus_err);
        n_both       += int'(mem_ack && bus_err);
        n_req_cycles += int'(bus_req);
        prev_bus_req  = bus_req;
    endtask

    task automatic clear_logs();
        n_if_ack = 0; n_mem_ack = 0; n_err = 0; n_both = 0; n_req_cycles = 0;
        addr_log.delete();
        rise_cyc.delete();
    endtask

    // One clock: compare mid-cycle, step the model on the edge, then let the
    // requesters retire acknowledged requests and the slave respond.
    task automatic cycle();
        logic pia, pma;
        @(negedge clk);
        compare_all();
        observe();
        @(posedge clk);
        pia = m_if_ack;
        pma = m_mem_ack;
        model_step();
        #1;
        if (pia) if_req  = 1'b0;
        if (pma) mem_req = 1'b0;
        if (m_busy) begin
            if (sl_mode == 1) bus_ack = ($urandom_range(2) == 0);
            else              bus_ack = (sl_delay >= 0) && (sl_age == sl_delay);
            sl_age++;
        end else begin
            sl_age  = 0;
            bus_ack = (sl_mode == 1) ? ($urandom_range(7) == 0) : 1'b0;
        end
        bus_rdata = (sl_mode == 1) ? 32'($urandom) : sl_data;
        cyc++;
    endtask

    initial begin
        rst = 1'b0; if_req = 0; mem_req = 0; mem_we = 0; flush = 0; bus_ack = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_sel = '0; bus_rdata = '0;
        sl_mode = 0; sl_delay = 0; sl_age = 0; sl_data = '0; cyc = 0;
        prev_bus_req = 0; last_we = 0; last_sel = '0; last_wdata = '0;
        model_reset();
        clear_logs();

        // Reset state.
        #1;
        check("reset_bus_req",  64'(bus_req),   64'h0);
        check("reset_if_data",  64'(if_data),   64'h0);
        check("reset_mem_data", 64'(mem_rdata), 64'h0);
        check("reset_stall",    64'(stallreq),  64'h0);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();

        // Fetch with a slave that acks on its fourth bus cycle.
        clear_logs();
        sl_delay = 3; sl_data = 32'h3C010001;
        if_addr = 32'h100; if_req = 1'b1;
        repeat (10) cycle();
        check("t1_if_ack_count", 64'(n_if_ack),     64'd1);
        check("t1_if_data",      64'(if_data),      64'h3C010001);
        check("t1_bus_addr",     64'(addr_log[0]),  64'h100);
        check("t1_req_cycles",   64'(n_req_cycles), 64'd4);

        // Simultaneous requests: load wins, fetch follows after one idle cycle.
        clear_logs();
        sl_delay = 0; sl_data = 32'hA5A50002;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h104;
        repeat (12) cycle();
        check("t2_grants",       64'(addr_log.size()),          64'd2);
        check("t2_first_addr",   64'(addr_log[0]),              64'h2000);
        check("t2_second_addr",  64'(addr_log[1]),              64'h104);
        check("t2_gap",          64'(rise_cyc[1] - rise_cyc[0]), 64'd2);
        check("t2_mem_acks",     64'(n_mem_ack),                64'd1);
        check("t2_if_acks",      64'(n_if_ack),                 64'd1);

        // Store: lanes and data held from grant to ack despite input changes.
        clear_logs();
        sl_delay = 2; sl_data = 32'h11112222;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
        mem_addr = 32'h3000; mem_wdata = 32'hDEADBEEF;
        repeat (2) cycle();
        mem_sel = 4'hF; mem_wdata = 32'h0;
        repeat (5) cycle();
        check("t3_we",       64'(last_we),      64'h1);
        check("t3_sel",      64'(last_sel),     64'h3);
        check("t3_wdata",    64'(last_wdata),   64'hDEADBEEF);
        check("t3_mem_acks", 64'(n_mem_ack),    64'd1);
        check("t3_req_cyc",  64'(n_req_cycles), 64'd3);

        // Flush during a fetch: result dropped, refetch granted afterwards.
        clear_logs();
        sl_delay = 3; sl_data = 32'h0BADF00D;
        if_addr = 32'h200; if_req = 1'b1;
        repeat (2) cycle();
        flush = 1'b1; if_addr = 32'h300;
        cycle();
        flush = 1'b0;
        repeat (2) cycle();
        sl_delay = 0; sl_data = 32'h24210005;
        cycle();
        check("t4_no_ack_flushed", 64'(n_if_ack), 64'd0);
        repeat (5) cycle();
        check("t4_refetch_addr", 64'(addr_log[1]), 64'h300);
        check("t4_if_acks",      64'(n_if_ack),    64'd1);
        check("t4_if_data",      64'(if_data),     64'h24210005);

        // Watchdog: slave never answers a load.
        clear_logs();
        sl_delay = -1;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h4000;
        repeat (8) cycle();
        check("t5_req_cycles", 64'(n_req_cycles), 64'd4);
        check("t5_mem_acks",   64'(n_mem_ack),    64'd1);
        check("t5_err",        64'(n_err),        64'd1);
        check("t5_err_w_ack",  64'(n_both),       64'd1);
        check("t5_rdata_zero", 64'(mem_rdata),    64'h0);

        // Reset in the middle of a load, then a fresh load.
        clear_logs();
        mem_req = 1'b1; mem_addr = 32'h5000;
        repeat (3) cycle();
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_bus_req",   64'(bus_req),  64'h0);
        check("t6_stall",     64'(stallreq), 64'h0);
        check("t6_if_data",   64'(if_data),  64'h0);
        check("t6_bus_addr",  64'(bus_addr), 64'h0);
        repeat (2) cycle();
        rst = 1'b1;
        clear_logs();
        sl_delay = 1; sl_data = 32'h600DF00D; mem_addr = 32'h6000;
        repeat (6) cycle();
        check("t6_mem_acks",  64'(n_mem_ack),   64'd1);
        check("t6_addr",      64'(addr_log[0]), 64'h6000);
        check("t6_rdata",     64'(mem_rdata),   64'h600DF00D);

        // Randomized traffic against the model.
        sl_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!if_req && $urandom_range(3) == 0) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom) & 32'hFFFF_FFFC;
            end
            if (!mem_req && $urandom_range(3) == 0) begin
                mem_req   = 1'b1;
                mem_we    = 1'($urandom_range(1));
                mem_sel   = 4'($urandom_range(15, 1));
                mem_addr  = 32'($urandom);
                mem_wdata = 32'($urandom);
            end
            flush = ($urandom_range(15) == 0);
            if (flush && if_req) if_addr = 32'($urandom) & 32'hFFFF_FFFC;
            cycle();
        end
        flush = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
